// File: rtl/rca_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: slice width,
// FSM state encoding and the slice-count helper.
package rca_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational SLICE_W-bit ripple-carry adder; the one arithmetic
// resource time-shared by the sequencer.
module ripple_carry_adder
    import rca_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] s,
    output logic               c_out
);

    logic [SLICE_W:0] chain;

    assign chain[0] = c_in;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ chain[i];
        assign chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end

    assign c_out = chain[SLICE_W];

endmodule

// File: rtl/rca_multiword_sequencer.sv
// Adds or subtracts WIDTH-bit operands one nibble per clock through a single
// shared ripple-carry adder, LSB slice first, with the carry registered between slices.
module rca_multiword_sequencer
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 2 * SLICE_W) begin : g_bad_width
        $error("rca_multiword_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_eff_q;
    logic [WIDTH-1:0]   sum_q;
    logic               c_out_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [SLICE_W-1:0] rca_a;
    logic [SLICE_W-1:0] rca_b;
    logic [SLICE_W-1:0] rca_s;
    logic               rca_co;
    logic               ovf_d;

    always_comb begin
        rca_a = a_q[idx_q*SLICE_W +: SLICE_W];
        rca_b = b_eff_q[idx_q*SLICE_W +: SLICE_W];
    end

    ripple_carry_adder u_rca (
        .a     (rca_a),
        .b     (rca_b),
        .c_in  (carry_q),
        .s     (rca_s),
        .c_out (rca_co)
    );

    // Signed overflow: operands agree in sign but the MSB slice result does not.
    assign ovf_d = (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) && (rca_s[SLICE_W-1] != a_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_eff_q <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_eff_q <= sub ? ~op_b : op_b;
                        carry_q <= sub ? 1'b1 : c_in;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_q[idx_q*SLICE_W +: SLICE_W] <= rca_s;
                    carry_q <= rca_co;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        c_out_q <= rca_co;
                        ovf_q   <= ovf_d;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

    a_busy_done_exclusive: assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));
    a_idx_in_range:        assert property (@(posedge clk) disable iff (rst) idx_q <= LAST_IDX);

endmodule

// File: tb/tb_rca_multiword_sequencer.sv
// Scoreboard bench for rca_multiword_sequencer at WIDTH=16: a reference model
// queues expected results at start, a monitor pops and compares on every done.
module tb_rca_multiword_sequencer;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cOut;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic             cIn;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cOut;
    logic             overflow;

    exp_t expQ[$];
    int   checkCount;
    int   passCount;
    logic heldCout;
    logic heldOvf;

    rca_multiword_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .c_in     (cIn),
        .op_a     (opA),
        .op_b     (opB),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (cOut),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t modelOp(input logic s, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic ci);
        exp_t           e;
        logic [WIDTH-1:0] bEff;
        logic [WIDTH:0]   full;
        bEff   = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bEff} + (WIDTH+1)'(s ? 1'b1 : ci);
        e.sum  = full[WIDTH-1:0];
        e.cOut = full[WIDTH];
        e.ovf  = (a[WIDTH-1] == bEff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Compare every completed result against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousDone", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sum",      32'(sum),      32'(e.sum));
                checkOutput("cOut",     32'(cOut),     32'(e.cOut));
                checkOutput("overflow", 32'(overflow), 32'(e.ovf));
                heldCout = e.cOut;
                heldOvf  = e.ovf;
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic ci, input bit pokeStart);
        @(negedge clk);
        sub   = s;
        opA   = a;
        opB   = b;
        cIn   = ci;
        start = 1'b1;
        expQ.push_back(modelOp(s, a, b, ci));
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyC1",  32'(busy),     32'd1);
        checkOutput("doneC1",  32'(done),     32'd0);
        checkOutput("sumClr",  32'(sum),      32'd0);
        checkOutput("coutHold", 32'(cOut),    32'(heldCout));
        checkOutput("ovfHold", 32'(overflow), 32'(heldOvf));
        for (int k = 2; k <= NSLICE; k++) begin
            @(negedge clk);
            if (pokeStart && k == 2) begin
                start = 1'b1;
                opA   = 16'hAAAA;
                opB   = 16'h5555;
                sub   = ~s;
            end else begin
                start = 1'b0;
            end
            checkOutput("busyRun", 32'(busy), 32'd1);
            checkOutput("doneRun", 32'(done), 32'd0);
        end
        @(negedge clk);
        checkOutput("doneCyc", 32'(done), 32'd1);
        checkOutput("busyDone", 32'(busy), 32'd0);
        start = pokeStart;
        if (pokeStart) begin
            opA = 16'h0F0F;
            opB = 16'h3333;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        passCount  = 0;
        heldCout   = 1'b0;
        heldOvf    = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cIn   = 1'b0;
        opA   = '0;
        opB   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstBusy", 32'(busy),     32'd0);
        checkOutput("rstDone", 32'(done),     32'd0);
        checkOutput("rstSum",  32'(sum),      32'd0);
        checkOutput("rstCout", 32'(cOut),     32'd0);
        checkOutput("rstOvf",  32'(overflow), 32'd0);

        applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h00FF, 16'h0F00, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);

        // Abort an operation with reset in its cycle 2.
        @(negedge clk);
        sub   = 1'b0;
        opA   = 16'h1111;
        opB   = 16'h2222;
        cIn   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        heldCout = 1'b0;
        heldOvf  = 1'b0;
        checkOutput("abortBusy", 32'(busy),     32'd0);
        checkOutput("abortDone", 32'(done),     32'd0);
        checkOutput("abortSum",  32'(sum),      32'd0);
        checkOutput("abortCout", 32'(cOut),     32'd0);
        checkOutput("abortOvf",  32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("abortNoDone", 32'(done), 32'd0);
        end

        applyStimulus(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (4) @(negedge clk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
